d_cmp_sched: RTL
================

# d_cmp_sched

Pipeline scheduler for the decode-stage branch comparator. It tracks every in-flight register write in the E, M and W stages and the busy state of the multiply/divide unit. Each cycle it decides whether the instruction in D must stall, which stage forwards each comparator operand, and whether the comparator result is valid this cycle. It sits between the D-stage decoder and the D_CMP/operand-mux datapath, and its stall output feeds the F/D pipeline-register enables.

## Interface
Parameters
- `NSTAGE`, 3: number of tracked stages after D (E, M, W); fixed at 3 for this core.

Ports
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high; clears all scoreboard state.
- `flush`  in  1  exception/eret flush; invalidates all tracked entries.
- `d_rs`, `d_rt`  in  5 each  source registers of the D instruction.
- `d_tuse_rs`, `d_tuse_rt`  in  2 each  cycles until D needs the operand (0 = compare in D).
- `d_dst`  in  5  destination register of the D instruction (0 = none).
- `d_tnew`  in  2  cycles after entering E until the result can be forwarded.
- `d_is_branch`  in  1  D holds beq/bne.
- `d_is_md`  in  1  D holds a mult/div/mfhi/mflo/mthi/mtlo.
- `e_md_start`  in  1  the E instruction starts the MDU this cycle.
- `md_busy`  in  1  MDU is iterating.
- `stall`  out  1  hold F/D and insert a bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel`  out  2 each  operand source: RF=0, E=1, M=2, W=3.
- `cmp_valid`  out  1  `d_is_branch && !stall`; gates b_jump use.

## Operation
- Scoreboard: one slot per stage (E, M, W). Each slot holds `valid`, `dst[4:0]` and `tnew[1:0]`.
- Each clock edge, with `flush` and `reset` low:
  - W ← M, then M ← E, with tnew decremented and saturating at 0.
  - E ← {1, d_dst, d_tnew} when `!stall`; otherwise E ← bubble (valid=0).
- `flush`, sampled synchronously, clears all valid bits. It has priority over shifting and loading.
- Match rule: a slot matches operand r when it is valid, r≠0, and dst==r.
- Data stall: for each operand, take the nearest matching slot, with priority E > M > W. Stall if that slot's tnew > the operand's tuse.
- MDU stall: `d_is_md && (md_busy || e_md_start)`.
- `stall` = data stall on rs OR data stall on rt OR MDU stall.
- Forward select for each operand:
  - The stage code of the nearest matching slot, if that slot has tnew==0.
  - RF if no slot matches.
  - When stalled, the select value is don't-care but must be deterministic: use the same rule.
- Only the nearest matching slot counts. An older slot never overrides a younger match, even if the older one is ready.
- `stall`, `fwd_*_sel` and `cmp_valid` are combinational from the registered slots plus D inputs. There is no internal FSM beyond the slot pipeline.

## Timing
- Reset values:
  - All slots invalid, tnew=0.
  - Outputs then follow from the D inputs: with idle MDU inputs, `stall`=0, `fwd_*_sel`=0 (RF), and `cmp_valid`=`d_is_branch`.
- Reset asserted mid-operation clears the slots immediately (asynchronously), without waiting for a clock edge.
- Stall latency:
  - Producer with tnew=1 immediately ahead of a branch: 1 stall cycle, then forward from M.
  - Load (tnew=2) immediately ahead of a branch: 2 stall cycles, then forward from W.
- MDU stall persists while `md_busy`. It releases in the cycle `md_busy` falls.
- Same cycle `flush` and `stall`: the flush wins, and all slots are invalid after the edge.
- rs==rt with both matching: both selects show the same stage.
- d_dst=0 loads a slot that can never match (harmless).

## Structure
- Shared constants in `def.v`:
  - `FWD_RF`/`FWD_E`/`FWD_M`/`FWD_W`
  - `TNEW_W` (=2)
  - `TUSE_BR` (=0)
- One sub-module, `sched_slot`: a single scoreboard register with load, bubble and flush inputs and a saturating tnew decrement. It is instantiated three times (E, M, W).
- The match, priority and stall logic stays in the top module.

## Test plan
- addu $1 (tnew=1) then beq $1,$2: stall=1 for 1 cycle, then fwd_rs_sel=2 and cmp_valid=1.
- lw $3 (tnew=2) then bne $0,$3: stall=1 for 2 cycles, then fwd_rt_sel=3; fwd_rs_sel=0 throughout, since $0 never matches.
- lui $4 (tnew=0) then beq $4,$4: no stall; fwd_rs_sel=fwd_rt_sel=1.
- Two writers to $5: ALU tnew=1 in M, and lw tnew=2 in E. Branch on $5 must stall (nearest = E) and must not forward the stale M value.
- mult in E (e_md_start=1), mflo in D, md_busy high for 5 cycles: stall=1 for 6 cycles total, then 0.
- Flush (or reset pulse) while lw $6 occupies E: next cycle a beq on $6 shows stall=0 and fwd_rs_sel=0.

Source files
------------

// File: rtl/d_cmp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d_cmp_sched_pkg
// Purpose  : Shared constants, slot record and helpers for the decode-stage
//            branch-comparator scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package d_cmp_sched_pkg;

    // Operand source codes; E/M/W codes equal (slot index + 1)
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam int         TNEW_W  = 2;
    localparam logic [1:0] TUSE_BR = 2'd0;

    // One tracked in-flight register write
    typedef struct packed {
        logic              valid;
        logic [4:0]        dst;
        logic [TNEW_W-1:0] tnew;
    } slot_t;

    // tnew counts down one per stage and stops at zero
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // $0 is never a real producer, so it never matches
    function automatic logic slot_match(input slot_t s, input logic [4:0] r);
        return s.valid && (r != 5'd0) && (s.dst == r);
    endfunction

endpackage : d_cmp_sched_pkg
`default_nettype wire

// File: rtl/d_cmp_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : d_cmp_sched_if
// Purpose  : D-stage request / scheduler response bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface d_cmp_sched_if;
    logic       flush;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic       d_is_branch;
    logic       d_is_md;
    logic       e_md_start;
    logic       md_busy;
    logic       stall;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       cmp_valid;

    modport master (
        output flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_is_branch, d_is_md, e_md_start, md_busy,
        input  stall, fwd_rs_sel, fwd_rt_sel, cmp_valid
    );

    modport slave (
        input  flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_is_branch, d_is_md, e_md_start, md_busy,
        output stall, fwd_rs_sel, fwd_rt_sel, cmp_valid
    );
endinterface : d_cmp_sched_if
`default_nettype wire

// File: rtl/d_cmp_sched_slot.sv
`default_nettype none
// ============================================================================
// Module   : sched_slot
// Purpose  : One scoreboard register (E, M or W) with load, bubble and flush,
//            optionally decrementing tnew as the entry moves down the pipe.
// Revision : 1.0 - initial release
// ============================================================================
module sched_slot
    import d_cmp_sched_pkg::*;
#(
    parameter logic DEC = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  i_flush,
    input  wire logic  i_load,
    input  wire logic  i_bubble,
    input  wire slot_t i_slot,
    output slot_t      o_slot
);

    slot_t r_slot;

    // Slot register: flush beats bubble beats load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= '0;
        end else if (i_flush || i_bubble) begin
            r_slot.valid <= 1'b0;
        end else if (i_load) begin
            r_slot.valid <= i_slot.valid;
            r_slot.dst   <= i_slot.dst;
            r_slot.tnew  <= DEC ? tnew_dec(i_slot.tnew) : i_slot.tnew;
        end
    end

    assign o_slot = r_slot;

endmodule : sched_slot
`default_nettype wire

// File: rtl/d_cmp_sched.sv
`default_nettype none
// ============================================================================
// Module   : d_cmp_sched
// Purpose  : Decode-stage scheduler: tracks E/M/W writers and the MDU, and
//            produces stall, per-operand forward selects and cmp_valid.
// Revision : 1.0 - initial release
// ============================================================================
module d_cmp_sched
    import d_cmp_sched_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input wire logic      clk,
    input wire logic      reset,
    d_cmp_sched_if.slave  bus
);

    slot_t      w_slot [NSTAGE];
    slot_t      w_d_slot;
    logic       w_stall;
    logic       w_rs_hit, w_rt_hit;
    logic [1:0] w_rs_tnew, w_rt_tnew;
    logic [1:0] w_rs_code, w_rt_code;
    logic       w_rs_stall, w_rt_stall, w_md_stall;
    logic [1:0] w_rs_sel, w_rt_sel;

    assign w_d_slot = '{valid: 1'b1, dst: bus.d_dst, tnew: bus.d_tnew};

    // Slot 0 is E (loaded from D or bubbled), later slots shift every cycle
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_slot
        if (gi == 0) begin : g_head
            sched_slot #(.DEC(1'b0)) u_slot (
                .clk      (clk),
                .reset    (reset),
                .i_flush  (bus.flush),
                .i_load   (!w_stall),
                .i_bubble (w_stall),
                .i_slot   (w_d_slot),
                .o_slot   (w_slot[gi])
            );
        end else begin : g_tail
            sched_slot #(.DEC(1'b1)) u_slot (
                .clk      (clk),
                .reset    (reset),
                .i_flush  (bus.flush),
                .i_load   (1'b1),
                .i_bubble (1'b0),
                .i_slot   (w_slot[gi-1]),
                .o_slot   (w_slot[gi])
            );
        end
    end

    // Nearest-match search: scan oldest to youngest so the youngest hit wins
    always_comb begin
        w_rs_hit  = 1'b0;
        w_rt_hit  = 1'b0;
        w_rs_tnew = '0;
        w_rt_tnew = '0;
        w_rs_code = FWD_RF;
        w_rt_code = FWD_RF;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (slot_match(w_slot[i], bus.d_rs)) begin
                w_rs_hit  = 1'b1;
                w_rs_tnew = w_slot[i].tnew;
                w_rs_code = 2'(i + 1);
            end
            if (slot_match(w_slot[i], bus.d_rt)) begin
                w_rt_hit  = 1'b1;
                w_rt_tnew = w_slot[i].tnew;
                w_rt_code = 2'(i + 1);
            end
        end
    end

    // Stall and forward decision; a matching but unready producer selects RF
    always_comb begin
        w_rs_stall = w_rs_hit && (w_rs_tnew > bus.d_tuse_rs);
        w_rt_stall = w_rt_hit && (w_rt_tnew > bus.d_tuse_rt);
        w_md_stall = bus.d_is_md && (bus.md_busy || bus.e_md_start);
        w_stall    = w_rs_stall || w_rt_stall || w_md_stall;
        w_rs_sel   = (w_rs_hit && (w_rs_tnew == '0)) ? w_rs_code : FWD_RF;
        w_rt_sel   = (w_rt_hit && (w_rt_tnew == '0)) ? w_rt_code : FWD_RF;
    end

    assign bus.stall      = w_stall;
    assign bus.fwd_rs_sel = w_rs_sel;
    assign bus.fwd_rt_sel = w_rt_sel;
    assign bus.cmp_valid  = bus.d_is_branch && !w_stall;

endmodule : d_cmp_sched
`default_nettype wire
